// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtractor: one 1-bit full-subtractor cell walks the operands LSB-first,
// with valid/ready handshakes on the operand and result sides.
module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             borrowIn,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrowOut,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] xShift_q, xShift_d;
    logic [WIDTH-1:0] yShift_q, yShift_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             borrow_q, borrow_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             inReady_q, inReady_d;
    logic             outValid_q, outValid_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrowOut_q, borrowOut_d;

    logic             cellDiff;
    logic             cellBorrow;
    logic [WIDTH-1:0] resultShifted;

    always_comb begin
        cellDiff      = xShift_q[0] ^ yShift_q[0] ^ borrow_q;
        cellBorrow    = (~xShift_q[0] & yShift_q[0]) | (~(xShift_q[0] ^ yShift_q[0]) & borrow_q);
        resultShifted = {cellDiff, result_q[WIDTH-1:1]};
    end

    // The counter holds on the last bit so it never wraps within an operation.
    always_comb begin
        state_d     = state_q;
        xShift_d    = xShift_q;
        yShift_d    = yShift_q;
        result_d    = result_q;
        borrow_d    = borrow_q;
        count_d     = count_q;
        inReady_d   = inReady_q;
        outValid_d  = outValid_q;
        busy_d      = busy_q;
        diff_d      = diff_q;
        borrowOut_d = borrowOut_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid && inReady_q) begin
                    xShift_d  = x;
                    yShift_d  = y;
                    borrow_d  = borrowIn;
                    result_d  = '0;
                    count_d   = '0;
                    inReady_d = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = RUN;
                end
            end
            RUN: begin
                result_d = resultShifted;
                xShift_d = xShift_q >> 1;
                yShift_d = yShift_q >> 1;
                borrow_d = cellBorrow;
                if (count_q == LAST_BIT) begin
                    diff_d      = resultShifted;
                    borrowOut_d = cellBorrow;
                    outValid_d  = 1'b1;
                    state_d     = DONE;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    outValid_d = 1'b0;
                    inReady_d  = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: begin
                outValid_d = 1'b0;
                inReady_d  = 1'b1;
                busy_d     = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            xShift_q    <= '0;
            yShift_q    <= '0;
            result_q    <= '0;
            borrow_q    <= 1'b0;
            count_q     <= '0;
            inReady_q   <= 1'b1;
            outValid_q  <= 1'b0;
            busy_q      <= 1'b0;
            diff_q      <= '0;
            borrowOut_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            xShift_q    <= xShift_d;
            yShift_q    <= yShift_d;
            result_q    <= result_d;
            borrow_q    <= borrow_d;
            count_q     <= count_d;
            inReady_q   <= inReady_d;
            outValid_q  <= outValid_d;
            busy_q      <= busy_d;
            diff_q      <= diff_d;
            borrowOut_q <= borrowOut_d;
        end
    end

    assign in_ready  = inReady_q;
    assign out_valid = outValid_q;
    assign busy      = busy_q;
    assign diff      = diff_q;
    assign borrowOut = borrowOut_q;

    // Exactly one of the two handshake sides is open at any time outside RUN.
    assert property (@(posedge clk) disable iff (reset) !(inReady_q && outValid_q));
    assert property (@(posedge clk) disable iff (reset) busy_q == !inReady_q);

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Self-checking bench for serial_subtractor_ctrl: directed corner cases plus a
// back-to-back random sweep against an arithmetic reference model.
module tb_serial_subtractor_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         borrowIn;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         borrowOut;
    logic         busy;

    int vectorCount = 0;
    int missCount   = 0;

    serial_subtractor_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x        (x),
        .y        (y),
        .borrowIn (borrowIn),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .diff     (diff),
        .borrowOut(borrowOut),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // {borrowOut, diff} straight from integer subtraction one bit wider than the operands.
    function automatic logic [W:0] refSub(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        logic [W:0] r;
        r = {1'b0, a} - {1'b0, b} - (W+1)'(bin);
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Accepts one operation and waits (bounded) for out_valid; returns edges counted after accept.
    task automatic startOp(input logic [W-1:0] xa, input logic [W-1:0] ya, input logic ba, output int edges);
        checkOutput("inReadyIdle", 32'(in_ready), 32'd1);
        x        = xa;
        y        = ya;
        borrowIn = ba;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        x        = W'($urandom);
        y        = W'($urandom);
        borrowIn = 1'($urandom);
        checkOutput("busyRun", 32'(busy), 32'd1);
        checkOutput("inReadyRun", 32'(in_ready), 32'd0);
        edges = 0;
        while (!out_valid && edges < 40) begin
            @(posedge clk);
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic applyStimulus(input logic [W-1:0] xa, input logic [W-1:0] ya, input logic ba,
                                 input logic [W-1:0] expDiff, input logic expBorrow);
        int edges;
        startOp(xa, ya, ba, edges);
        checkOutput("latency", 32'(edges), 32'(W));
        checkOutput("diff", 32'(diff), 32'(expDiff));
        checkOutput("borrowOut", 32'(borrowOut), 32'(expBorrow));
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("outValidDrop", 32'(out_valid), 32'd0);
        checkOutput("inReadyBack", 32'(in_ready), 32'd1);
        checkOutput("diffHeld", 32'(diff), 32'(expDiff));
    endtask

    initial begin
        int         edges;
        logic [W:0] expected;
        logic [W:0] expQ[$];
        logic [W-1:0] ra, rb;
        logic       rc;
        logic       sawValid;
        int         results;
        int         cyc;
        int         lastAccept;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x         = '0;
        y         = '0;
        borrowIn  = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rstInReady", 32'(in_ready), 32'd1);
        checkOutput("rstOutValid", 32'(out_valid), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstDiff", 32'(diff), 32'd0);
        checkOutput("rstBorrow", 32'(borrowOut), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        applyStimulus(8'h05, 8'h03, 1'b0, 8'h02, 1'b0);
        applyStimulus(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1);
        applyStimulus(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);
        applyStimulus(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        applyStimulus(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0);
        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            expected = refSub(ra, rb, rc);
            applyStimulus(ra, rb, rc, expected[W-1:0], expected[W]);
        end

        // Backpressure: result must stay put and a fresh request must be ignored.
        expected = refSub(8'h5A, 8'h33, 1'b1);
        startOp(8'h5A, 8'h33, 1'b1, edges);
        checkOutput("bpLatency", 32'(edges), 32'(W));
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            x        = W'($urandom);
            y        = W'($urandom);
            @(posedge clk);
            @(negedge clk);
            checkOutput("bpOutValid", 32'(out_valid), 32'd1);
            checkOutput("bpInReady", 32'(in_ready), 32'd0);
            checkOutput("bpDiff", 32'(diff), 32'(expected[W-1:0]));
            checkOutput("bpBorrow", 32'(borrowOut), 32'(expected[W]));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("bpInReadyAfter", 32'(in_ready), 32'd1);
        checkOutput("bpOutValidAfter", 32'(out_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("bpNoSecondOp", 32'(busy), 32'd0);

        // Reset three edges into a run.
        x        = 8'h77;
        y        = 8'h11;
        borrowIn = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("midRstInReady", 32'(in_ready), 32'd1);
        checkOutput("midRstOutValid", 32'(out_valid), 32'd0);
        checkOutput("midRstBusy", 32'(busy), 32'd0);
        checkOutput("midRstDiff", 32'(diff), 32'd0);
        checkOutput("midRstBorrow", 32'(borrowOut), 32'd0);
        @(negedge clk);
        reset    = 1'b0;
        sawValid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) sawValid = 1'b1;
        end
        checkOutput("midRstNoPulse", 32'(sawValid), 32'd0);
        applyStimulus(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0);

        // Back-to-back sweep with both handshakes tied high.
        results    = 0;
        cyc        = 0;
        lastAccept = -1;
        in_valid   = 1'b1;
        out_ready  = 1'b1;
        while (results < 1000 && cyc < 15000) begin
            if (out_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("sweepQueue", 32'd0, 32'd1);
                end else begin
                    expected = expQ.pop_front();
                    checkOutput("sweepDiff", 32'(diff), 32'(expected[W-1:0]));
                    checkOutput("sweepBorrow", 32'(borrowOut), 32'(expected[W]));
                end
                results++;
            end
            x        = W'($urandom);
            y        = W'($urandom);
            borrowIn = 1'($urandom);
            if (in_ready) begin
                expQ.push_back(refSub(x, y, borrowIn));
                if (lastAccept >= 0) checkOutput("issueInterval", 32'(cyc - lastAccept), 32'(W + 2));
                lastAccept = cyc;
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        checkOutput("sweepDone", 32'(results), 32'd1000);
        in_valid  = 1'b0;
        out_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
